// File: rtl/writeback_control.sv
// Register-file write-port controller for the W stage.
// Resolves the in-order writeback of the W instruction and arbitrates it
// against the late result of a single in-flight multi-cycle mul/div. When
// both want the port in the same cycle, the md result waits one slot.
module writeback_control #(
   parameter logic [4:0] RSTATUS_REG = 5'd30,
   parameter logic [4:0] RA_REG      = 5'd31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [31:0] wb_insn,
   input  logic [31:0] wb_alu_result,
   input  logic [31:0] wb_mem_data,
   input  logic [31:0] wb_pc_plus1,
   input  logic        wb_ovf,
   input  logic        md_start,
   input  logic [31:0] md_insn,
   input  logic [31:0] md_result,
   input  logic        md_ready,
   input  logic        md_exception,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        md_busy,
   output logic [4:0]  md_dest,
   output logic        wb_stall
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_SRA  = 5'b00101;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  dest_q, dest_d;
   logic        is_div_q, is_div_d;
   logic        kill_q, kill_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic        buf_exc_q, buf_exc_d;

   // True when an instruction word is an R-type mul or div.
   function automatic logic is_muldiv(input logic [31:0] insn);
      return (insn[31:27] == OP_RTYPE) &&
             ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
   endfunction

   logic [4:0]  wb_op, wb_alu_op, wb_rd;
   logic        pipe_en;
   logic [4:0]  pipe_reg;
   logic [31:0] pipe_data;
   logic        pipe_wr;

   assign wb_op     = wb_insn[31:27];
   assign wb_alu_op = wb_insn[6:2];
   assign wb_rd     = wb_insn[26:22];

   // Decode the W instruction into a write request; an overflow redirects
   // the write to the status register with a per-opcode code.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      pipe_en   = 1'b0;
      pipe_reg  = 5'd0;
      pipe_data = 32'd0;
      if (wb_valid) begin
         case (wb_op)
            OP_RTYPE: begin
               // Only add/sub/and/or/sll/sra write; mul/div go via the md path.
               if (wb_alu_op <= ALU_SRA) begin
                  pipe_en = 1'b1;
                  if (wb_ovf && (wb_alu_op == ALU_ADD)) begin
                     pipe_reg  = RSTATUS_REG;
                     pipe_data = 32'd1;
                  end else if (wb_ovf && (wb_alu_op == ALU_SUB)) begin
                     pipe_reg  = RSTATUS_REG;
                     pipe_data = 32'd3;
                  end else begin
                     pipe_reg  = wb_rd;
                     pipe_data = wb_alu_result;
                  end
               end
            end
            OP_ADDI: begin
               pipe_en = 1'b1;
               if (wb_ovf) begin
                  pipe_reg  = RSTATUS_REG;
                  pipe_data = 32'd2;
               end else begin
                  pipe_reg  = wb_rd;
                  pipe_data = wb_alu_result;
               end
            end
            OP_LW: begin
               pipe_en   = 1'b1;
               pipe_reg  = wb_rd;
               pipe_data = wb_mem_data;
            end
            OP_JAL: begin
               pipe_en   = 1'b1;
               pipe_reg  = RA_REG;
               pipe_data = wb_pc_plus1;
            end
            OP_SETX: begin
               pipe_en   = 1'b1;
               pipe_reg  = RSTATUS_REG;
               pipe_data = {5'd0, wb_insn[26:0]};
            end
            default: ;
         endcase
      end
   end

   // A write to $r0 is no write at all, so it neither collides nor kills.
   assign pipe_wr = pipe_en && (pipe_reg != 5'd0);

   logic        md_sel_exc;
   logic [31:0] md_sel_data;
   logic        md_wr_en;
   logic [4:0]  md_wr_reg;
   logic [31:0] md_wr_data;

   // Form the md write from either the live result (BUSY) or the buffer (HOLD).
   // Exceptions always report; a normal result is dropped if a younger write won.
   always_comb begin
      md_sel_exc  = (state_q == ST_HOLD) ? buf_exc_q  : md_exception;
      md_sel_data = (state_q == ST_HOLD) ? buf_data_q : md_result;
      if (md_sel_exc) begin
         md_wr_en   = 1'b1;
         md_wr_reg  = RSTATUS_REG;
         md_wr_data = is_div_q ? 32'd5 : 32'd4;
      end else begin
         md_wr_en   = !kill_q && (dest_q != 5'd0);
         md_wr_reg  = dest_q;
         md_wr_data = md_sel_data;
      end
   end

   // Next-state, tracking registers and write-port arbitration.
   always_comb begin
      state_d          = state_q;
      dest_d           = dest_q;
      is_div_d         = is_div_q;
      kill_d           = kill_q;
      buf_data_d       = buf_data_q;
      buf_exc_d        = buf_exc_q;
      ctrl_writeEnable = pipe_wr;
      ctrl_writeReg    = pipe_reg;
      data_writeReg    = pipe_data;
      wb_stall         = 1'b0;
      md_busy          = (state_q != ST_IDLE);
      md_dest          = (state_q != ST_IDLE) ? dest_q : 5'd0;

      case (state_q)
         ST_IDLE: begin
            if (md_start && is_muldiv(md_insn)) begin
               state_d  = ST_BUSY;
               dest_d   = md_insn[26:22];
               is_div_d = (md_insn[6:2] == ALU_DIV);
               kill_d   = 1'b0;
            end
         end
         ST_BUSY: begin
            if (pipe_wr && (pipe_reg == dest_q)) begin
               kill_d = 1'b1;
            end
            if (md_ready) begin
               if (pipe_wr) begin
                  // Pipeline keeps the port; the result waits one slot.
                  state_d    = ST_HOLD;
                  buf_data_d = md_result;
                  buf_exc_d  = md_exception;
               end else begin
                  state_d          = ST_IDLE;
                  ctrl_writeEnable = md_wr_en;
                  ctrl_writeReg    = md_wr_reg;
                  data_writeReg    = md_wr_data;
               end
            end
         end
         ST_HOLD: begin
            // The older md result goes first; a pipeline write is held off.
            state_d          = ST_IDLE;
            wb_stall         = pipe_wr;
            ctrl_writeEnable = md_wr_en;
            ctrl_writeReg    = md_wr_reg;
            data_writeReg    = md_wr_data;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!reset) begin
         ctrl_writeEnable = 1'b0;
         ctrl_writeReg    = 5'd0;
         data_writeReg    = 32'd0;
         md_busy          = 1'b0;
         md_dest          = 5'd0;
         wb_stall         = 1'b0;
      end
   end

   // State and tracking registers, synchronously cleared by reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs, regardless of statement order.
      if (!reset) begin
         state_q    <= ST_IDLE;
         dest_q     <= 5'd0;
         is_div_q   <= 1'b0;
         kill_q     <= 1'b0;
         buf_data_q <= 32'd0;
         buf_exc_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dest_q     <= dest_d;
         is_div_q   <= is_div_d;
         kill_q     <= kill_d;
         buf_data_q <= buf_data_d;
         buf_exc_q  <= buf_exc_d;
      end
   end

endmodule

// File: tb/tb_writeback_control.sv
// Directed bench for writeback_control: pipeline decode, overflow codes,
// mul/div tracking, collision buffering, WAW kill and reset behaviour.
module tb_writeback_control;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [31:0] wb_insn;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_mem_data;
   logic [31:0] wb_pc_plus1;
   logic        wb_ovf;
   logic        md_start;
   logic [31:0] md_insn;
   logic [31:0] md_result;
   logic        md_ready;
   logic        md_exception;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        md_busy;
   logic [4:0]  md_dest;
   logic        wb_stall;

   int errors = 0;
   int checks = 0;

   writeback_control dut (
      .clock            (clock),
      .reset            (reset),
      .wb_valid         (wb_valid),
      .wb_insn          (wb_insn),
      .wb_alu_result    (wb_alu_result),
      .wb_mem_data      (wb_mem_data),
      .wb_pc_plus1      (wb_pc_plus1),
      .wb_ovf           (wb_ovf),
      .md_start         (md_start),
      .md_insn          (md_insn),
      .md_result        (md_result),
      .md_ready         (md_ready),
      .md_exception     (md_exception),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .md_busy          (md_busy),
      .md_dest          (md_dest),
      .wb_stall         (wb_stall)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic en, input logic [4:0] rg,
                           input logic [31:0] data);
      check({tag, ".en"}, {31'd0, ctrl_writeEnable}, {31'd0, en});
      if (en) begin
         check({tag, ".reg"},  {27'd0, ctrl_writeReg}, {27'd0, rg});
         check({tag, ".data"}, data_writeReg, data);
      end
   endtask

   function automatic logic [31:0] r_insn(input logic [4:0] rd, input logic [4:0] alu);
      return {5'b00000, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd);
      return {op, rd, 5'd1, 17'd0};
   endfunction

   // Advance to just after the next rising edge and clear all inputs.
   task automatic next_cycle();
      @(posedge clock);
      #1;
      wb_valid      = 1'b0;
      wb_insn       = 32'd0;
      wb_alu_result = 32'd0;
      wb_mem_data   = 32'd0;
      wb_pc_plus1   = 32'd0;
      wb_ovf        = 1'b0;
      md_start      = 1'b0;
      md_insn       = 32'd0;
      md_result     = 32'd0;
      md_ready      = 1'b0;
      md_exception  = 1'b0;
   endtask

   task automatic settle();
      #3;
   endtask

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00110, DIV = 5'b00111;

   initial begin
      reset = 1'b0;
      next_cycle();
      // Outputs forced low in reset even with a writing instruction at W.
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd5); wb_alu_result = 32'd7;
      settle();
      check("rst.en",   {31'd0, ctrl_writeEnable}, 32'd0);
      check("rst.reg",  {27'd0, ctrl_writeReg}, 32'd0);
      check("rst.data", data_writeReg, 32'd0);
      check("rst.busy", {31'd0, md_busy}, 32'd0);
      next_cycle();
      reset = 1'b1;

      // Pipeline decode.
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd5); wb_alu_result = 32'd7;
      settle(); check_wr("addi", 1'b1, 5'd5, 32'd7);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd0); wb_alu_result = 32'd7;
      settle(); check_wr("addi_r0", 1'b0, 5'd0, 32'd0);
      next_cycle();
      wb_valid = 1'b1; wb_insn = r_insn(5'd9, ADD); wb_ovf = 1'b1; wb_alu_result = 32'hFFFF;
      settle(); check_wr("add_ovf", 1'b1, 5'd30, 32'd1);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd9); wb_ovf = 1'b1;
      settle(); check_wr("addi_ovf", 1'b1, 5'd30, 32'd2);
      next_cycle();
      wb_valid = 1'b1; wb_insn = r_insn(5'd9, SUB); wb_ovf = 1'b1;
      settle(); check_wr("sub_ovf", 1'b1, 5'd30, 32'd3);
      next_cycle();
      wb_valid = 1'b1; wb_insn = {5'b00011, 27'd16}; wb_pc_plus1 = 32'h40;
      settle(); check_wr("jal", 1'b1, 5'd31, 32'h40);
      next_cycle();
      wb_valid = 1'b1; wb_insn = {5'b10101, 27'h123};
      settle(); check_wr("setx", 1'b1, 5'd30, 32'h123);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b01000, 5'd6); wb_mem_data = 32'hCAFE;
      settle(); check_wr("lw", 1'b1, 5'd6, 32'hCAFE);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b00111, 5'd6);
      settle(); check_wr("sw", 1'b0, 5'd0, 32'd0);
      next_cycle();
      wb_valid = 1'b1; wb_insn = r_insn(5'd3, MUL);
      settle(); check_wr("mul_at_w", 1'b0, 5'd0, 32'd0);
      next_cycle();
      wb_valid = 1'b0; wb_insn = i_insn(5'b00101, 5'd5);
      settle(); check_wr("invalid", 1'b0, 5'd0, 32'd0);

      // Non-mul/div md_start is ignored.
      next_cycle();
      md_start = 1'b1; md_insn = r_insn(5'd3, ADD);
      next_cycle();
      settle(); check("ignored.busy", {31'd0, md_busy}, 32'd0);

      // mul $3, ready 5 cycles later, W idle; a second md_start mid-flight is ignored.
      md_start = 1'b1; md_insn = r_insn(5'd3, MUL);
      settle(); check("mul.busy0", {31'd0, md_busy}, 32'd0);
      for (int i = 1; i < 5; i++) begin
         next_cycle();
         if (i == 2) begin md_start = 1'b1; md_insn = r_insn(5'd9, DIV); end
         settle();
         check("mul.busy", {31'd0, md_busy}, 32'd1);
         check("mul.dest", {27'd0, md_dest}, 32'd3);
         check_wr("mul.nowr", 1'b0, 5'd0, 32'd0);
      end
      next_cycle();
      md_ready = 1'b1; md_result = 32'hDEAD;
      settle();
      check("mul.busy_rdy", {31'd0, md_busy}, 32'd1);
      check_wr("mul.wr", 1'b1, 5'd3, 32'hDEAD);
      next_cycle();
      settle();
      check("mul.idle", {31'd0, md_busy}, 32'd0);
      check("mul.dest0", {27'd0, md_dest}, 32'd0);

      // div $4 collides with lw $6; buffered write next cycle stalls a second lw.
      md_start = 1'b1; md_insn = r_insn(5'd4, DIV);
      next_cycle();
      next_cycle();
      md_ready = 1'b1; md_result = 32'h44;
      wb_valid = 1'b1; wb_insn = i_insn(5'b01000, 5'd6); wb_mem_data = 32'h66;
      settle();
      check_wr("col.c0", 1'b1, 5'd6, 32'h66);
      check("col.c0stall", {31'd0, wb_stall}, 32'd0);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b01000, 5'd6); wb_mem_data = 32'h66;
      settle();
      check_wr("col.c1", 1'b1, 5'd4, 32'h44);
      check("col.c1stall", {31'd0, wb_stall}, 32'd1);
      check("col.c1busy", {31'd0, md_busy}, 32'd1);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b01000, 5'd6); wb_mem_data = 32'h66;
      settle();
      check_wr("col.c2", 1'b1, 5'd6, 32'h66);
      check("col.c2stall", {31'd0, wb_stall}, 32'd0);
      check("col.c2busy", {31'd0, md_busy}, 32'd0);

      // WAW kill: addi $7 lands before mul $7 result.
      next_cycle();
      md_start = 1'b1; md_insn = r_insn(5'd7, MUL);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd7); wb_alu_result = 32'd9;
      settle(); check_wr("kill.addi", 1'b1, 5'd7, 32'd9);
      next_cycle();
      md_ready = 1'b1; md_result = 32'h77;
      settle();
      check_wr("kill.md", 1'b0, 5'd0, 32'd0);
      check("kill.busy", {31'd0, md_busy}, 32'd1);
      next_cycle();
      settle(); check("kill.idle", {31'd0, md_busy}, 32'd0);

      // Same scenario with an exception: the exception still reports.
      md_start = 1'b1; md_insn = r_insn(5'd7, MUL);
      next_cycle();
      wb_valid = 1'b1; wb_insn = i_insn(5'b00101, 5'd7); wb_alu_result = 32'd9;
      next_cycle();
      md_ready = 1'b1; md_result = 32'h77; md_exception = 1'b1;
      settle(); check_wr("exc.mul", 1'b1, 5'd30, 32'd4);

      // div exception without collision reports code 5.
      next_cycle();
      md_start = 1'b1; md_insn = r_insn(5'd8, DIV);
      next_cycle();
      md_ready = 1'b1; md_exception = 1'b1;
      settle(); check_wr("exc.div", 1'b1, 5'd30, 32'd5);

      // Reset mid-BUSY discards the op; a later md_ready does nothing.
      next_cycle();
      md_start = 1'b1; md_insn = r_insn(5'd8, MUL);
      next_cycle();
      settle(); check("rb.busy", {31'd0, md_busy}, 32'd1);
      next_cycle();
      reset = 1'b0;
      settle();
      check("rb.busy_rst", {31'd0, md_busy}, 32'd0);
      check("rb.dest_rst", {27'd0, md_dest}, 32'd0);
      next_cycle();
      reset = 1'b1;
      md_ready = 1'b1; md_result = 32'h88;
      settle();
      check_wr("rb.ready", 1'b0, 5'd0, 32'd0);
      check("rb.busy_after", {31'd0, md_busy}, 32'd0);

      next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_control.md
Name: writeback_control

Overview:
- Write-side counterpart to decode's register-read control: drives the single register-file write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg) from the W stage.
- Decodes the W instruction's destination for all writing types: R-type, addi, lw, jal, setx, and overflow exceptions to $r30.
- Tracks one in-flight multi-cycle mul/div and arbitrates its late result against in-order writeback, buffering it for one slot on collision.

Parameters:
RSTATUS_REG, 5'd30, exception/setx destination
RA_REG, 5'd31, jal link destination

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
wb_valid  in  1  W stage holds a real instruction
wb_insn  in  32  W instruction
wb_alu_result  in  32  ALU result carried to W
wb_mem_data  in  32  load data
wb_pc_plus1  in  32  PC+1 of W instruction
wb_ovf  in  1  ALU overflow of W instruction
md_start  in  1  mul/div issued from X this cycle
md_insn  in  32  instruction issued with md_start
md_result  in  32  multdiv result
md_ready  in  1  one-cycle result-ready pulse
md_exception  in  1  multdiv exception, valid with md_ready
ctrl_writeEnable  out  1  register-file write enable
ctrl_writeReg  out  5  write address
data_writeReg  out  32  write data
md_busy  out  1  mul/div in flight or buffered; upstream must stall new mul/div
md_dest  out  5  destination of tracked mul/div, for decode hazard compare
wb_stall  out  1  W write deferred this cycle; pipeline must hold W

Behaviour:
- op = insn[31:27]; ALU op = insn[6:2]; rd = insn[26:22]; mul = R-type with ALU op 00110, div = R-type with ALU op 00111.
- Pipeline write request (combinational, only when wb_valid):
  - R-type add/sub/and/or/sll/sra, addi (00101): rd <- wb_alu_result.
  - lw (01000): rd <- wb_mem_data.
  - jal (00011): RA_REG <- wb_pc_plus1.
  - setx (10101): RSTATUS_REG <- zero-extended insn[26:0].
  - wb_ovf on add, addi, sub: RSTATUS_REG <- 1, 2, 3 respectively; replaces the rd write.
  - mul/div at W: no write (handled by the md path). sw, j, bne, jr, blt, bex: no write.
- Any resolved write with address 0 is forced to ctrl_writeEnable=0.
- FSM states IDLE, BUSY, HOLD; registers dest, is_div, kill, buf_data, buf_exc.
  - IDLE: md_start with mul/div md_insn -> BUSY; latch dest=md_insn[26:22], is_div, kill=0. md_start with non-mul/div md_insn is ignored.
  - BUSY, md_ready, no pipeline request: md write this cycle -> IDLE.
  - BUSY, md_ready, pipeline request present: pipeline writes; latch md_result/md_exception into buf_data/buf_exc -> HOLD.
  - HOLD: buffered write issued. If a pipeline request also exists: wb_stall=1, pipeline not written. -> IDLE.
- md write content:
  - Normal: dest <- result.
  - Exception: RSTATUS_REG <- 4 (mul) or 5 (div); kill does not apply.
  - Non-exception write suppressed (enable 0, state still advances) when kill=1.
- kill rule: set in BUSY/HOLD whenever a pipeline write targets dest (younger writer wins, WAW). A pipeline write in the same cycle as md_ready also sets kill before buffering.
- md_start while BUSY/HOLD is ignored (upstream violation; no state change).
- md_busy=1 in BUSY and HOLD. md_dest=dest in BUSY/HOLD, else 0.
- Latency: pipeline writes 0 cycles (combinational in the W cycle). md result is written in the md_ready cycle, or the next cycle on collision.
- Reset low: state IDLE and all registers 0. While reset is low all outputs are forced 0 (ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, md_busy=0, md_dest=0, wb_stall=0). Reset mid-BUSY discards the op; a later md_ready in IDLE is ignored.

Test Plan:
- addi $5,$0,7 at W with alu=7 -> en=1, reg=5, data=7; same with rd=0 -> en=0.
- add with wb_ovf=1 -> reg=30, data=1; addi overflow -> data=2; jal with pc_plus1=0x40 -> reg=31, data=0x40; setx T=0x123 -> reg=30, data=0x123.
- mul $3 issued, md_ready 5 cycles later, W idle -> md_busy=1 throughout, md_dest=3, write reg=3 data=result on ready cycle, then IDLE.
- div $4 ready while lw $6 at W -> cycle0: reg=6 mem data; cycle1: reg=4 buffered data. Lw arriving again in cycle1 -> wb_stall=1.
- mul $7 in flight, addi $7 written at W before ready -> md write suppressed (en=0 on ready cycle); same scenario with md_exception -> reg=30, data=4.
- reset low during BUSY, then md_ready pulse -> no write, md_busy=0.
